tpu_bram_dma: RTL

Layer-to-layer BRAM copy engine for the TPU. It is launched by the layer controller (`start_dma_o`, `nth_conv_o`) once a layer's pooled output is complete. It streams that layer's output feature map from the result BRAM into the input-feature BRAM for the next layer. On finishing it returns a single-cycle completion pulse that drives the controller's `dma_done_i`. It runs fully pipelined: one word read and one word written per cycle, behind a 1-cycle-latency BRAM read port.

---
 rtl/tpu_bram_dma.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tpu_bram_dma.sv
// Layer-to-layer BRAM copy engine: streams LENn words from the result BRAM into the
// next layer's input BRAM at one word per cycle, behind a 1-cycle-latency read port.
module tpu_bram_dma #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 0,
    parameter int LEN0     = 1176,
    parameter int LEN1     = 400,
    parameter int LEN2     = 120,
    parameter int LEN3     = 84
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        nth_conv_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              src_en_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [DATA_W-1:0] src_rdata_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] dst_wdata_o
);

    localparam longint MAX_BASE = (SRC_BASE > DST_BASE) ? longint'(SRC_BASE) : longint'(DST_BASE);
    localparam longint SPACE    = (longint'(1) << ADDR_W) - MAX_BASE;

    generate
        if (longint'(LEN0) > SPACE || longint'(LEN1) > SPACE ||
            longint'(LEN2) > SPACE || longint'(LEN3) > SPACE) begin : g_len_check
            $error("tpu_bram_dma: a LENn exceeds the address space above the base");
        end
    endgenerate

    localparam logic [ADDR_W:0] SRC_BASE_W = (ADDR_W+1)'(SRC_BASE);
    localparam logic [ADDR_W:0] DST_BASE_W = (ADDR_W+1)'(DST_BASE);
    localparam logic [ADDR_W:0] ONE_W      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

    function automatic logic [ADDR_W:0] len_sel(input logic [1:0] sel);
        case (sel)
            2'd0:    len_sel = (ADDR_W+1)'(LEN0);
            2'd1:    len_sel = (ADDR_W+1)'(LEN1);
            2'd2:    len_sel = (ADDR_W+1)'(LEN2);
            default: len_sel = (ADDR_W+1)'(LEN3);
        endcase
    endfunction

    state_t            state_q;
    logic [ADDR_W:0]   len_q, rcnt_q, wcnt_q;
    logic              src_en_q, rd_valid_q, done_q;
    logic [ADDR_W-1:0] src_addr_q, dst_addr_q;
    logic [ADDR_W:0]   start_len_d;
    logic [ADDR_W-1:0] src_addr_d, dst_addr_d;

    always_comb begin
        start_len_d = len_sel(nth_conv_i);
        src_addr_d  = ADDR_W'(SRC_BASE_W + rcnt_q);
        dst_addr_d  = ADDR_W'(DST_BASE_W + wcnt_q);
    end

    // rcnt_q counts reads already issued; the first read is issued on the start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            src_en_q   <= 1'b0;
            src_addr_q <= '0;
            rd_valid_q <= 1'b0;
            dst_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= src_en_q;
            if (src_en_q) begin
                dst_addr_q <= dst_addr_d;
                wcnt_q     <= wcnt_q + ONE_W;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q  <= start_len_d;
                        wcnt_q <= '0;
                        if (start_len_d != '0) begin
                            state_q    <= COPY;
                            src_en_q   <= 1'b1;
                            src_addr_q <= ADDR_W'(SRC_BASE_W);
                            rcnt_q     <= ONE_W;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            rcnt_q  <= '0;
                        end
                    end
                end
                COPY: begin
                    if (rcnt_q == len_q) begin
                        state_q  <= DRAIN;
                        src_en_q <= 1'b0;
                    end else begin
                        src_addr_q <= src_addr_d;
                        rcnt_q     <= rcnt_q + ONE_W;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q == COPY) || (state_q == DRAIN);
    assign done_o      = done_q;
    assign src_en_o    = src_en_q;
    assign src_addr_o  = src_addr_q;
    assign dst_we_o    = rd_valid_q;
    assign dst_addr_o  = dst_addr_q;
    assign dst_wdata_o = src_rdata_i;

endmodule
